// File: rtl/grf_pkg.sv
// Shared definitions for the general-purpose register file.
// Holds the default geometry, the hardwired-zero register index,
// the write trace format, and the pending-write counter type used
// by the scoreboard.
package grf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register index that always reads as zero and ignores writes.
  localparam int REG_ZERO = 0;

  // Text layout of one committed-write trace line: pc, register, data.
  localparam string TRACE_FMT = "@%h: $%d <= %h";

  // Outstanding-write count for one register; 3 means no more issues.
  typedef logic [1:0] pend_t;

  localparam pend_t PEND_ZERO = 2'd0;
  localparam pend_t PEND_ONE  = 2'd1;
  localparam pend_t PEND_MAX  = 2'd3;

endpackage

// File: rtl/grf_sb_cnt.sv
// Pending-write counter for a single register.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high clear of count and err
//   inc    - an instruction targeting this register was accepted at issue
//   dec    - write-back to this register this cycle
//   count  - current number of outstanding writes
//   err    - registered pulse: a write-back arrived while count was zero
module grf_sb_cnt
  import grf_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  inc,
  input  logic  dec,
  output pend_t count,
  output logic  err
);

  // Count moves up on issue and down on write-back; both together
  // cancel out. The count saturates at both ends, so an unexpected
  // write-back leaves it at zero and is reported through err instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= PEND_ZERO;
      err   <= 1'b0;
    end else begin
      err <= dec && (count == PEND_ZERO);
      case ({inc, dec})
        2'b10:   if (count != PEND_MAX)  count <= count + 2'd1;
        2'b01:   if (count != PEND_ZERO) count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grf_param.sv
// Parametrised register file for the pipelined CPU.
// Several combinational read ports with write-through bypass, one
// write-back port, and a per-register pending-write scoreboard that
// decode uses to stall. Register 0 is hardwired to zero.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   rd_addr / rd_data   - packed read addresses and data, port k at slice k
//   rd_busy             - per-port: register still awaiting a write-back
//   iss_en / iss_addr   - decode issues an instruction writing iss_addr
//   iss_ok              - the issue is accepted this cycle
//   wr_en/addr/data/pc  - write-back port; pc is used only by the trace
//   sb_err              - pulse one cycle after a write-back with nothing pending
module grf_param
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int LOG_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ok,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [31:0]              wr_pc,
  output logic                     sb_err
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREG];
  pend_t             pend [NREG];
  logic [NREG-1:0]   inc;
  logic [NREG-1:0]   dec;
  logic [NREG-1:0]   err;
  logic [ADDR_W-1:0] ra;
  logic              byp;

  // Issue is refused only when the destination already has the
  // maximum number of writes in flight; register 0 never blocks.
  assign iss_ok = !reset && ((iss_addr == ZERO_ADDR) || (pend[iss_addr] != PEND_MAX));

  // Per-register increment/decrement strobes for the scoreboard.
  // Register 0 has no counter, so its strobes stay low.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = iss_en && iss_ok && (iss_addr == ADDR_W'(r));
      dec[r] = wr_en && (wr_addr == ADDR_W'(r));
    end
  end

  // One pending counter per architectural register except register 0.
  generate
    for (genvar r = 0; r < NREG; r++) begin : g_sb
      if (r == REG_ZERO) begin : g_zero
        assign pend[r] = PEND_ZERO;
        assign err[r]  = 1'b0;
      end else begin : g_cnt
        grf_sb_cnt u_cnt (
          .clk   (clk),
          .reset (reset),
          .inc   (inc[r]),
          .dec   (dec[r]),
          .count (pend[r]),
          .err   (err[r])
        );
      end
    end
  endgenerate

  // Each counter's err is already a flop, so the OR stays registered.
  assign sb_err = |err;

  // Storage: cleared by reset; writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports. A write-back to the same nonzero register is forwarded
  // so decode sees the value in the same cycle. A register whose only
  // outstanding write is completing right now is therefore not busy.
  // While reset is high every port reads zero and nothing is busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    byp     = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra  = rd_addr[k*ADDR_W +: ADDR_W];
      byp = !reset && wr_en && (wr_addr == ra) && (ra != ZERO_ADDR);
      if (!reset) begin
        if (byp) begin
          rd_data[k*DATA_W +: DATA_W] = wr_data;
        end else if (ra != ZERO_ADDR) begin
          rd_data[k*DATA_W +: DATA_W] = regs[ra];
        end
        rd_busy[k] = (pend[ra] != PEND_ZERO) && !((pend[ra] == PEND_ONE) && byp);
      end
    end
  end

`ifndef SYNTHESIS
  // Write trace: one line per committed write to a nonzero register.
  always_ff @(posedge clk) begin
    if ((LOG_EN != 0) && !reset && wr_en && (wr_addr != ZERO_ADDR)) begin
      $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data);
    end
  end
`endif

endmodule

// File: tb/tb_grf_param.sv
// Self-checking bench for grf_param (default parameters, two read ports).
// Stimulus drives one vector per cycle just after the rising edge and
// queues the expected outputs; a monitor on the falling edge pops every
// queued expectation and compares it against the live DUT outputs.
module tb_grf_param;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic            iss_ok;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [31:0]     wr_pc;
  logic            sb_err;

  grf_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .LOG_EN(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_ok   (iss_ok),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_pc    (wr_pc),
    .sb_err   (sb_err)
  );

  always #5 clk = ~clk;

  // Which DUT output an expectation refers to.
  typedef enum int {SEL_D0, SEL_D1, SEL_B0, SEL_B1, SEL_OK, SEL_ERR} sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t expq[$];
  int   npass  = 0;
  int   ntotal = 0;

  function automatic logic [31:0] actualOf(sel_e s);
    case (s)
      SEL_D0:  return rd_data[31:0];
      SEL_D1:  return rd_data[63:32];
      SEL_B0:  return {31'd0, rd_busy[0]};
      SEL_B1:  return {31'd0, rd_busy[1]};
      SEL_OK:  return {31'd0, iss_ok};
      default: return {31'd0, sb_err};
    endcase
  endfunction

  // Monitor: compare everything queued for this cycle at the falling edge.
  always @(negedge clk) begin
    while (expq.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = expq.pop_front();
      act = actualOf(e.sel);
      ntotal++;
      if (act === e.exp) begin
        npass++;
      end else begin
        $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  // Drive one input vector just after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                               input logic ie, input logic [AW-1:0] ia,
                               input logic we, input logic [AW-1:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset    = rst;
    rd_addr  = {ra1, ra0};
    iss_en   = ie;
    iss_addr = ia;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    wr_pc    = wr_pc + 32'd4;
  endtask

  // Queue an expectation for the vector currently applied.
  task automatic checkOutput(input string name, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    expq.push_back(e);
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; iss_en = 1'b0; iss_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_pc = 32'h0000_1000;

    // Reset held: everything reads zero, issue refused.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_iss_ok", SEL_OK, 0);
    checkOutput("rst_d0", SEL_D0, 0);
    checkOutput("rst_b0", SEL_B0, 0);

    // Read all registers after reset.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, AW'(i), AW'(31 - i), 0, 0, 0, 0, 0);
      checkOutput("init_d0", SEL_D0, 0);
      checkOutput("init_d1", SEL_D1, 0);
      checkOutput("init_b0", SEL_B0, 0);
      checkOutput("init_b1", SEL_B1, 0);
      checkOutput("init_ok", SEL_OK, 1);
    end

    // Write $5 with nothing pending: bypass now, stored next, sb_err pulses.
    applyStimulus(0, 5, 5, 0, 0, 1, 5, 32'h1234_5678);
    checkOutput("w5_bypass", SEL_D0, 32'h1234_5678);
    checkOutput("w5_err_pre", SEL_ERR, 0);
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("w5_stored", SEL_D0, 32'h1234_5678);
    checkOutput("w5_err_pulse", SEL_ERR, 1);

    // Write $0 is dropped.
    applyStimulus(0, 0, 5, 0, 0, 1, 0, 32'hFFFF_FFFF);
    checkOutput("w0_bypass", SEL_D0, 0);
    checkOutput("w0_err", SEL_ERR, 0);
    checkOutput("w5_keep", SEL_D1, 32'h1234_5678);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("w0_stored", SEL_D0, 0);
    checkOutput("w0_err_next", SEL_ERR, 0);

    // Issue $7 three times, fourth refused, then three write-backs.
    applyStimulus(0, 7, 0, 1, 7, 0, 0, 0);
    checkOutput("i7a_ok", SEL_OK, 1);
    checkOutput("i7a_busy", SEL_B0, 0);
    applyStimulus(0, 7, 0, 1, 7, 0, 0, 0);
    checkOutput("i7b_ok", SEL_OK, 1);
    checkOutput("i7b_busy", SEL_B0, 1);
    applyStimulus(0, 7, 0, 1, 7, 0, 0, 0);
    checkOutput("i7c_ok", SEL_OK, 1);
    applyStimulus(0, 7, 0, 1, 7, 0, 0, 0);
    checkOutput("i7d_full", SEL_OK, 0);
    checkOutput("i7d_busy", SEL_B0, 1);
    applyStimulus(0, 7, 0, 0, 7, 1, 7, 32'h70);
    checkOutput("wb7a_busy", SEL_B0, 1);
    checkOutput("wb7a_data", SEL_D0, 32'h70);
    checkOutput("wb7a_okfull", SEL_OK, 0);
    applyStimulus(0, 7, 0, 0, 7, 1, 7, 32'h71);
    checkOutput("wb7b_busy", SEL_B0, 1);
    applyStimulus(0, 7, 0, 0, 7, 1, 7, 32'h72);
    checkOutput("wb7c_busy", SEL_B0, 0);
    checkOutput("wb7c_data", SEL_D0, 32'h72);
    applyStimulus(0, 7, 0, 0, 7, 0, 0, 0);
    checkOutput("wb7_done_busy", SEL_B0, 0);
    checkOutput("wb7_done_data", SEL_D0, 32'h72);
    checkOutput("wb7_done_err", SEL_ERR, 0);
    checkOutput("wb7_done_ok", SEL_OK, 1);

    // $9: unexpected write-back, then issue + write-back in one cycle.
    applyStimulus(0, 9, 0, 0, 0, 1, 9, 32'h99);
    checkOutput("w9_bypass", SEL_D0, 32'h99);
    checkOutput("w9_busy", SEL_B0, 0);
    applyStimulus(0, 9, 0, 1, 9, 0, 0, 0);
    checkOutput("w9_err", SEL_ERR, 1);
    checkOutput("w9_stored", SEL_D0, 32'h99);
    applyStimulus(0, 9, 0, 1, 9, 1, 9, 32'h9A);
    checkOutput("iw9_busy", SEL_B0, 0);
    checkOutput("iw9_data", SEL_D0, 32'h9A);
    checkOutput("iw9_err", SEL_ERR, 0);
    applyStimulus(0, 9, 0, 0, 0, 0, 0, 0);
    checkOutput("iw9_pend_kept", SEL_B0, 1);
    checkOutput("iw9_stored", SEL_D0, 32'h9A);
    checkOutput("iw9_err_next", SEL_ERR, 0);

    // $3: three issues, one write-back of 0xAA leaves two pending.
    applyStimulus(0, 3, 9, 1, 3, 0, 0, 0);
    applyStimulus(0, 3, 9, 1, 3, 0, 0, 0);
    applyStimulus(0, 3, 9, 1, 3, 0, 0, 0);
    applyStimulus(0, 3, 9, 0, 0, 1, 3, 32'hAA);
    applyStimulus(0, 3, 9, 0, 0, 0, 0, 0);
    checkOutput("r3_pre_data", SEL_D0, 32'hAA);
    checkOutput("r3_pre_busy", SEL_B0, 1);
    checkOutput("r9_pre_busy", SEL_B1, 1);

    // Reset with a concurrent write to $3: ignored, all cleared.
    applyStimulus(1, 3, 9, 1, 3, 1, 3, 32'hBB);
    checkOutput("rst3_data", SEL_D0, 0);
    checkOutput("rst3_busy", SEL_B0, 0);
    checkOutput("rst3_ok", SEL_OK, 0);
    applyStimulus(0, 3, 9, 0, 0, 0, 0, 0);
    checkOutput("post3_data", SEL_D0, 0);
    checkOutput("post3_busy", SEL_B0, 0);
    checkOutput("post9_data", SEL_D1, 0);
    checkOutput("post9_busy", SEL_B1, 0);
    checkOutput("post_err", SEL_ERR, 0);

    // Late write-back after reset counts as unexpected.
    applyStimulus(0, 3, 0, 0, 0, 1, 3, 32'hCC);
    checkOutput("late3_bypass", SEL_D0, 32'hCC);
    applyStimulus(0, 3, 0, 0, 0, 0, 0, 0);
    checkOutput("late3_err", SEL_ERR, 1);
    checkOutput("late3_stored", SEL_D0, 32'hCC);

    // Let the monitor drain, with a bound.
    for (int n = 0; n < 10 && expq.size() > 0; n++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      $display("[TB] FAIL drain: got %0d unchecked expected 0", expq.size());
      ntotal += expq.size();
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/grf_param.md
# grf_param

Parametrised general-purpose register file for the pipelined CPU: multi-read-port, single write-back port, write-through bypass and a per-register pending-write scoreboard. It replaces the single-cycle two-port file in the ID stage. Decode uses `rd_busy`/`iss_ok` to generate stalls; WB drives the write port. Register 0 is hardwired to zero.

## Interface
- `DATA_W`, 32, register width.
- `ADDR_W`, 5, address width; depth = 2^ADDR_W.
- `NUM_RD`, 2, number of read ports (1..4).
- `LOG_EN`, 1, enables write trace via `$display`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all registers and the scoreboard.
- `rd_addr`  in  NUM_RD*ADDR_W  packed read addresses; port k is at bits [k*ADDR_W +: ADDR_W].
- `rd_data`  out  NUM_RD*DATA_W  packed read data, combinational.
- `rd_busy`  out  NUM_RD  port k's register has an outstanding write that is not bypassed this cycle.
- `iss_en`  in  1  decode issues an instruction that will write `iss_addr`.
- `iss_addr`  in  ADDR_W  destination of the issued instruction.
- `iss_ok`  out  1  issue is accepted this cycle.
- `wr_en`  in  1  write-back valid.
- `wr_addr`  in  ADDR_W  write-back destination.
- `wr_data`  in  DATA_W  write-back data.
- `wr_pc`  in  32  PC of the writing instruction; used for the trace only.
- `sb_err`  out  1  one-cycle pulse: write-back to a register with pending count 0 (nonzero address).

## Operation
- Storage: 2^ADDR_W x DATA_W. Reads of address 0 return 0. Writes to address 0 are dropped and are not traced.
- Read port k:
  - If `wr_en`, `wr_addr == rd_addr[k]`, `rd_addr[k] != 0` and `!reset`, then `rd_data[k] = wr_data` (bypass).
  - Otherwise `rd_data[k]` is the stored value.
- Scoreboard: 2-bit pending counter `pend[r]` per register. `pend[0]` is always 0.
  - `iss_ok = !reset && (iss_addr == 0 || pend[iss_addr] != 3)`.
  - Accepted issue (`iss_en && iss_ok`, nonzero addr) increments `pend[iss_addr]`.
  - Write-back with nonzero addr decrements `pend[wr_addr]` when it is > 0.
  - Write-back to a register with `pend == 0`: data is still written, counter stays 0, `sb_err` pulses the next cycle.
  - Accepted issue and write-back to the same register in one cycle: counter unchanged, data written.
  - `rd_busy[k] = pend[rd_addr[k]] != 0`, except when `pend == 1` and that register is being written this cycle. In that case bypass supplies the data and `rd_busy[k] = 0`.
- Trace: when `LOG_EN`, each committed write to a nonzero register prints `@%h: $%d <= %h` (wr_pc, wr_addr, wr_data) at the clock edge. No trace line is printed during `reset`.

## Timing
- Reads: zero latency, combinational from `rd_addr`, `wr_*` and state.
- Writes and counter updates: visible on the stored path the cycle after the edge. On the bypass path the write data is visible the same cycle.
- `sb_err`: registered; high exactly one cycle after the offending edge.
- Reset (synchronous, on the edge):
  - all registers = 0, all `pend` = 0, `sb_err` = 0.
  - While `reset` is high: `iss_ok` = 0, bypass disabled, writes ignored, so `rd_data` = 0 and `rd_busy` = 0.
- Reset in the middle of in-flight writes discards the pending counts. Write-backs arriving after reset are then treated as `sb_err` cases; this is a software/pipeline-flush concern and is not masked.
- Simultaneous read, issue and write-back to the same register: the read returns bypassed data. `rd_busy` reflects the pre-edge counter, with the bypass exception above.

## Structure
- Shared package `grf_pkg`: default `DATA_W`/`ADDR_W`, `REG_ZERO` constant, trace format string, and `pend_t` (2-bit).
- One sub-module, `grf_sb_cnt`: a single saturating up/down pending counter with inputs inc, dec and reset, and outputs count and err. It is instantiated 2^ADDR_W − 1 times via generate.
- The top level holds the storage array, read muxes with bypass, and the trace.

## Test plan
- Reset, then read all 32 registers -> every `rd_data` = 0, `rd_busy` = 0, `iss_ok` = 1.
- Write $5 = 0x1234_5678 with `rd_addr[0]` = 5 in the same cycle -> `rd_data[0]` = 0x1234_5678 combinationally. Trace prints `@<pc>: $ 5 <= 12345678`. Next cycle the stored read returns the same value.
- Write $0 = 0xFFFF_FFFF -> read $0 = 0, no trace line, `sb_err` = 0.
- Issue $7 three times -> `pend` = 3, `rd_busy` = 1, fourth issue sees `iss_ok` = 0. Three write-backs follow; during the third, `rd_busy` = 0 via bypass. Afterwards `pend` = 0.
- Write-back $9 with `pend` = 0 -> data stored, `sb_err` high one cycle. Issue and write-back $9 in the same cycle with `pend` = 1 -> `pend` stays 1.
- Assert `reset` with `pend[3]` = 2 and $3 = 0xAA -> next cycle $3 reads 0 and `rd_busy` = 0. A concurrent `wr_en` to $3 during `reset` is ignored.
